// File: rtl/pipe_pkg.sv
// Shared definitions for the control-bundle pipeline stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  localparam int IDEX_W = 11;

  // ID/EX control bundle, msb first.
  typedef struct packed {
    logic       shift;
    logic [3:0] alu;
    logic       size;
    logic       enable;
    logic       rw;
    logic       load;
    logic       s;
    logic       rf;
  } idex_t;

  localparam idex_t IDEX_NOP = '0;

endpackage

// File: rtl/pipe_ctrl_stage.sv
// Generic control-bundle stage register: valid/ready handshake, optional skid
// slot, flush-to-NOP and a saturating bubble counter.
module pipe_ctrl_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH   = IDEX_W,
  parameter logic [WIDTH-1:0] NOP_VAL = {WIDTH{1'b0}},
  parameter bit               SKID    = 1'b1,
  parameter int               CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic [WIDTH-1:0] In_Data,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic [WIDTH-1:0] Out_Data,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  input  logic             Flush,
  output logic [CNT_W-1:0] Bubble_Cnt,
  input  logic             Cnt_Clr
);

  stage_state_e     state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] cnt_q;
  logic             acc, con;

  assign Out_Valid  = (state_q != ST_EMPTY);
  assign Out_Data   = main_q;
  assign Bubble_Cnt = cnt_q;

  // The skid variant decodes ready purely from state so Out_Ready never
  // reaches In_Ready combinationally.
  generate
    if (SKID) begin : g_skid_rdy
      assign In_Ready = (state_q != ST_FULL);
    end else begin : g_comb_rdy
      assign In_Ready = Out_Ready | ~Out_Valid;
    end
  endgenerate

  assign acc = In_Valid & In_Ready;
  assign con = Out_Valid & Out_Ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (Flush) begin
      state_d = ST_EMPTY;
      main_d  = NOP_VAL;
      skid_d  = NOP_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d = ST_ONE;
            main_d  = In_Data;
          end
        end
        ST_ONE: begin
          if (con && acc) begin
            main_d = In_Data;
          end else if (con) begin
            state_d = ST_EMPTY;
            main_d  = NOP_VAL;
          end else if (acc) begin
            // Only reachable with SKID=1; without it acc implies con here.
            state_d = ST_FULL;
            skid_d  = In_Data;
          end
        end
        ST_FULL: begin
          if (con) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = NOP_VAL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = NOP_VAL;
          skid_d  = NOP_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= ST_EMPTY;
      main_q  <= NOP_VAL;
      skid_q  <= NOP_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      cnt_q <= '0;
    end else if (Cnt_Clr) begin
      cnt_q <= '0;
    end else if (!Out_Valid && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_stage.sv
// Scoreboard bench: a skid instance (CNT_W=4) under directed vectors and a
// combinational-ready instance under random traffic.
module tb_pipe_ctrl_stage;

  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;

  // skid instance (suffix 1)
  logic [10:0] i_data1, o_data1;
  logic        i_valid1, i_ready1, o_valid1, o_ready1, flush1, cnt_clr1;
  logic [3:0]  bcnt1;
  // combinational-ready instance (suffix 0)
  logic [10:0] i_data0, o_data0;
  logic        i_valid0, i_ready0, o_valid0, o_ready0, flush0, cnt_clr0;
  logic [15:0] bcnt0;

  pipe_ctrl_stage #(.WIDTH(11), .SKID(1'b1), .CNT_W(4)) u_dut1 (
    .CLK(clk), .CLR_N(clr_n),
    .In_Data(i_data1), .In_Valid(i_valid1), .In_Ready(i_ready1),
    .Out_Data(o_data1), .Out_Valid(o_valid1), .Out_Ready(o_ready1),
    .Flush(flush1), .Bubble_Cnt(bcnt1), .Cnt_Clr(cnt_clr1)
  );

  pipe_ctrl_stage #(.WIDTH(11), .SKID(1'b0), .CNT_W(16)) u_dut0 (
    .CLK(clk), .CLR_N(clr_n),
    .In_Data(i_data0), .In_Valid(i_valid0), .In_Ready(i_ready0),
    .Out_Data(o_data0), .Out_Valid(o_valid0), .Out_Ready(o_ready0),
    .Flush(flush0), .Bubble_Cnt(bcnt0), .Cnt_Clr(cnt_clr0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference models: queue of held entries plus a bubble counter.
  logic [10:0] q1[$];
  logic [10:0] q0[$];
  int cnt1_m = 0;
  int cnt0_m = 0;

  always @(negedge clk) begin
    logic        ev, er;
    logic [10:0] ed;
    if (!clr_n) begin
      q1.delete();
      cnt1_m = 0;
    end else begin
      ev = (q1.size() != 0);
      ed = ev ? q1[0] : 11'h000;
      er = (q1.size() < 2);
      chk("s1_valid", {31'd0, o_valid1}, {31'd0, ev});
      chk("s1_data", {21'd0, o_data1}, {21'd0, ed});
      chk("s1_ready", {31'd0, i_ready1}, {31'd0, er});
      chk("s1_bcnt", {28'd0, bcnt1}, cnt1_m);
      if (cnt_clr1) cnt1_m = 0;
      else if (!ev && cnt1_m != 15) cnt1_m++;
      if (flush1) q1.delete();
      else begin
        if (ev && o_ready1) void'(q1.pop_front());
        if (i_valid1 && er) q1.push_back(i_data1);
      end
    end
  end

  always @(negedge clk) begin
    logic        ev, er;
    logic [10:0] ed;
    if (!clr_n) begin
      q0.delete();
      cnt0_m = 0;
    end else begin
      ev = (q0.size() != 0);
      ed = ev ? q0[0] : 11'h000;
      er = o_ready0 || !ev;
      chk("s0_valid", {31'd0, o_valid0}, {31'd0, ev});
      chk("s0_data", {21'd0, o_data0}, {21'd0, ed});
      chk("s0_ready", {31'd0, i_ready0}, {31'd0, er});
      chk("s0_bcnt", {16'd0, bcnt0}, cnt0_m);
      if (cnt_clr0) cnt0_m = 0;
      else if (!ev && cnt0_m != 65535) cnt0_m++;
      if (flush0) q0.delete();
      else begin
        if (ev && o_ready0) void'(q0.pop_front());
        if (i_valid0 && er) q0.push_back(i_data0);
      end
    end
  end

  initial begin
    logic acc_ok;
    clr_n = 1'b0;
    {i_data1, i_valid1, o_ready1, flush1, cnt_clr1} = '0;
    {i_data0, i_valid0, o_ready0, flush0, cnt_clr0} = '0;
    #2;
    chk("rst_ready1", {31'd0, i_ready1}, 1);
    chk("rst_valid1", {31'd0, o_valid1}, 0);
    chk("rst_data1", {21'd0, o_data1}, 0);
    chk("rst_bcnt1", {28'd0, bcnt1}, 0);
    chk("rst_ready0", {31'd0, i_ready0}, 1);
    cyc(); cyc();
    clr_n = 1'b1;

    // back-to-back stream
    o_ready1 = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      i_valid1 = 1'b1;
      i_data1  = 11'(i);
      cyc();
      chk("stream_data", {21'd0, o_data1}, i);
    end
    i_valid1 = 1'b0;
    cyc(); cyc();

    // backpressure into the skid slot
    o_ready1 = 1'b0;
    i_valid1 = 1'b1;
    i_data1  = 11'h0A1; cyc();
    i_data1  = 11'h0A2; cyc();
    i_data1  = 11'h0A3;
    chk("a3_blocked", {31'd0, i_ready1}, 0);
    cyc(); cyc();
    o_ready1 = 1'b1;
    acc_ok = 1'b0;
    for (int k = 0; k < 10 && !acc_ok; k++) begin
      cyc();
      if (i_ready1) begin
        cyc();
        acc_ok = 1'b1;
      end
    end
    chk("a3_accept_bound", {31'd0, acc_ok}, 1);
    i_valid1 = 1'b0;
    repeat (3) cyc();
    chk("skid_drained", q1.size(), 0);

    // flush while FULL, offering 0x7FF
    o_ready1 = 1'b0;
    i_valid1 = 1'b1;
    i_data1  = 11'h0B1; cyc();
    i_data1  = 11'h0B2; cyc();
    flush1   = 1'b1;
    i_data1  = 11'h7FF; cyc();
    flush1   = 1'b0;
    i_valid1 = 1'b0;
    chk("flush_full_valid", {31'd0, o_valid1}, 0);
    chk("flush_full_data", {21'd0, o_data1}, 0);
    chk("flush_full_ready", {31'd0, i_ready1}, 1);
    // flush while ONE discards a same-cycle accept; refill on the next edge
    i_valid1 = 1'b1;
    i_data1  = 11'h0C1; cyc();
    flush1   = 1'b1;
    i_data1  = 11'h7FF; cyc();
    flush1   = 1'b0;
    chk("flush_one_valid", {31'd0, o_valid1}, 0);
    i_data1  = 11'h0C2; cyc();
    i_valid1 = 1'b0;
    chk("refill_valid", {31'd0, o_valid1}, 1);
    chk("refill_data", {21'd0, o_data1}, 11'h0C2);
    o_ready1 = 1'b1;
    cyc(); cyc();

    // asynchronous reset while FULL
    o_ready1 = 1'b0;
    i_valid1 = 1'b1;
    i_data1  = 11'h0D1; cyc();
    i_data1  = 11'h0D2; cyc();
    i_valid1 = 1'b0;
    #2 clr_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, o_valid1}, 0);
    chk("async_rst_data", {21'd0, o_data1}, 0);
    chk("async_rst_bcnt", {28'd0, bcnt1}, 0);
    chk("async_rst_ready", {31'd0, i_ready1}, 1);
    cyc();
    clr_n = 1'b1;

    // saturation and clear
    repeat (20) cyc();
    chk("bcnt_sat", {28'd0, bcnt1}, 15);
    cnt_clr1 = 1'b1; cyc();
    cnt_clr1 = 1'b0;
    chk("bcnt_clr", {28'd0, bcnt1}, 0);
    cyc();

    // random traffic on the combinational-ready stage
    for (int n = 0; n < 10000; n++) begin
      i_valid0 = 1'($urandom_range(0, 1));
      o_ready0 = 1'($urandom_range(0, 1));
      i_data0  = 11'($urandom);
      flush0   = ($urandom_range(0, 31) == 0);
      cnt_clr0 = ($urandom_range(0, 63) == 0);
      cyc();
    end
    i_valid0 = 1'b0;
    flush0   = 1'b0;
    cnt_clr0 = 1'b0;
    o_ready0 = 1'b1;
    repeat (3) cyc();
    chk("rand_drained", q0.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_stage.md
# pipe_ctrl_stage

Parametrised pipeline stage register for control bundles between decode, execute, memory and writeback. Replaces the fixed-field per-stage registers with one block: generic width, a valid/ready handshake with backpressure, synchronous flush that inserts a NOP bubble, an optional skid slot for full throughput under a registered ready, and a saturating bubble counter. One instance sits at each stage boundary.

## Interface
Parameters:
- WIDTH, 11, control bundle width (11 = ID/EX bundle: shift, alu[3:0], size, enable, rw, load, s, rf)
- NOP_VAL, {WIDTH{1'b0}}, Out_Data value whenever the stage holds no valid entry
- SKID, 1, 1 = two-entry stage with registered In_Ready; 0 = single register with combinational In_Ready
- CNT_W, 16, bubble counter width

Ports:
- CLK  in  1  rising-edge clock; the only clock
- CLR_N  in  1  asynchronous, active-low reset
- In_Data  in  WIDTH  control bundle from the upstream stage
- In_Valid  in  1  upstream entry present
- In_Ready  out  1  stage accepts an entry this cycle
- Out_Data  out  WIDTH  bundle to the downstream stage
- Out_Valid  out  1  Out_Data is a real instruction
- Out_Ready  in  1  downstream consumes this cycle
- Flush  in  1  synchronous kill of all held entries (branch taken / exception)
- Bubble_Cnt  out  CNT_W  cycles with Out_Valid=0, saturating
- Cnt_Clr  in  1  synchronous clear of Bubble_Cnt

## Operation
- Accept = In_Valid & In_Ready. Consume = Out_Valid & Out_Ready.
- Stored entries always come from In_Data. Out_Data shows the oldest entry, or NOP_VAL when empty. It never shows stale data.
- SKID=1 states:
  - EMPTY: no entry held.
  - ONE: main slot valid.
  - FULL: main and skid slots valid.
- SKID=1 transitions:
  - EMPTY → ONE on accept.
  - ONE → EMPTY on consume without accept.
  - ONE stays ONE on consume and accept together; main takes In_Data.
  - ONE → FULL on accept without consume; skid takes In_Data.
  - FULL → ONE on consume; skid moves to main.
- SKID=1: In_Ready = (state != FULL), driven from a register with no combinational path from Out_Ready.
- SKID=0: In_Ready = Out_Ready | ~Out_Valid, combinational. Only EMPTY and ONE are reachable.
- Flush = 1: next state EMPTY, both slots load NOP_VAL, and any same-cycle accept is discarded. Flush wins over every other event.
- Bubble_Cnt increments on every cycle with Out_Valid=0 and saturates at all-ones.
  - Cnt_Clr sets it to 0 and beats the increment in the same cycle.
  - Flush does not clear the counter.

## Timing
- Reset (CLR_N=0, asynchronous): state EMPTY, Out_Valid=0, Out_Data=NOP_VAL, Bubble_Cnt=0.
  - In_Ready=1 during reset for SKID=1. For SKID=0, In_Ready follows its equation.
  - Reset is released synchronously. Reset mid-transfer loses held entries with no partial output.
- Latency: an accept at edge N gives Out_Valid=1 with that data after edge N. One cycle, in both modes.
- Throughput: one entry per cycle while Out_Ready=1.
  - SKID=1 takes one extra entry after Out_Ready drops, then In_Ready=0 on the following cycle.
- Flush at edge N: Out_Valid=0 and Out_Data=NOP_VAL after edge N. An entry may be accepted again at edge N+1.
- Out_Valid and Out_Data are held stable while Out_Valid=1 & Out_Ready=0, except under Flush.
- Order is strict FIFO. No entry is dropped or duplicated except by Flush.

## Structure
- Shared package pipe_pkg holds:
  - The state enum (EMPTY/ONE/FULL).
  - The ID/EX bundle typedef and its width constant (11).
  - The NOP bundle constant.
- No sub-module. The skid slot and the counter are inline. The counter may be split out later as sat_counter if other stages reuse it.

## Test plan
- Reset, then drive In_Valid=1 with Out_Ready=1 and data 0x001..0x005 on consecutive cycles → Out_Data shows 0x001..0x005 one cycle later, back-to-back, with Out_Valid=1 throughout.
- SKID=1 with Out_Ready=0 and upstream offering 0x0A1, 0x0A2, 0x0A3 → 0x0A1 and 0x0A2 accepted, In_Ready=0 while 0x0A3 is offered. After Out_Ready=1: outputs 0x0A1, 0x0A2, 0x0A3 in order, none lost.
- Stage FULL and Flush=1 with In_Valid=1 (0x7FF) → next cycle Out_Valid=0, Out_Data=0x000, state EMPTY, 0x7FF discarded.
- CLR_N pulled low mid-cycle while FULL → Out_Valid=0 and Out_Data=0x000 immediately without a clock edge; Bubble_Cnt=0.
- CNT_W=4 and 20 idle cycles → Bubble_Cnt reaches 15 and holds. Cnt_Clr=1 on an idle cycle → Bubble_Cnt=0 next cycle.
- SKID=0, random In_Valid/Out_Ready for 10k cycles → scoreboard matches in order, and In_Ready == Out_Ready | ~Out_Valid on every cycle.
